datapath_controller: RTL and testbench

Multi-cycle control FSM that sequences the register-file/ALU datapath for one RISC-V instruction at a time. It accepts a 32-bit instruction over a valid/ready handshake, decodes RV32I R-type ALU ops and LUI, and drives the datapath's register addresses, ALU op and write enable. It also closes the write-back loop by registering `alu_result` (or the LUI immediate) and presenting it on `writedata`. It sits between the instruction source (fetch/ROM) and the datapath.

---
 rtl/riscv_ctrl_pkg.sv | 35 +++
 rtl/datapath_controller_if.sv | 27 ++
 rtl/instr_decoder.sv | 48 ++++
 rtl/datapath_controller.sv | 90 +++++++++
 tb/tb_datapath_controller.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared opcodes, ALU encodings, FSM states and decoded-instruction record for the
// datapath controller.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSlt = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StExec,
    StWb
  } ctrl_state_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       is_lui;
    logic       illegal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } dec_t;

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction handshake plus datapath control/write-back bus of the controller.
interface datapath_controller_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_result;
  logic [4:0]  rs_1;
  logic [4:0]  rs_2;
  logic [4:0]  rd_0;
  logic [2:0]  alu_control;
  logic        write_rb;
  logic [31:0] writedata;
  logic        busy;
  logic        done;
  logic        illegal;

  // Master is the instruction source / datapath side; slave is the controller.
  modport master (
    output instr_valid, instr, alu_result,
    input  instr_ready, rs_1, rs_2, rd_0, alu_control, write_rb, writedata, busy, done, illegal
  );

  modport slave (
    input  instr_valid, instr, alu_result,
    output instr_ready, rs_1, rs_2, rd_0, alu_control, write_rb, writedata, busy, done, illegal
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder covering the R-type ALU subset and LUI.
module instr_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] funct7;
  logic [2:0] funct3;

  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];

  always_comb begin
    dec         = '0;
    dec.alu_op  = AluAdd;
    dec.illegal = 1'b1;
    case (instr[6:0])
      OP_RTYPE: begin
        dec.illegal = 1'b0;
        case ({funct7, funct3})
          {7'h00, 3'b000}: dec.alu_op = AluAdd;
          {7'h20, 3'b000}: dec.alu_op = AluSub;
          {7'h00, 3'b111}: dec.alu_op = AluAnd;
          {7'h00, 3'b110}: dec.alu_op = AluOr;
          {7'h00, 3'b100}: dec.alu_op = AluXor;
          {7'h00, 3'b001}: dec.alu_op = AluSll;
          {7'h00, 3'b101}: dec.alu_op = AluSrl;
          {7'h00, 3'b010}: dec.alu_op = AluSlt;
          default:         dec.illegal = 1'b1;
        endcase
        if (!dec.illegal) begin
          dec.rs1 = instr[19:15];
          dec.rs2 = instr[24:20];
          dec.rd  = instr[11:7];
        end
      end
      OP_LUI: begin
        dec.illegal = 1'b0;
        dec.is_lui  = 1'b1;
        dec.rd      = instr[11:7];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_controller.sv
// Four-state sequencer driving the register-file/ALU datapath for one instruction at a
// time, with a registered write-back path.
module datapath_controller
  import riscv_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  datapath_controller_if.slave bus
);

  ctrl_state_t state_q;
  logic [31:0] instr_q;
  logic        is_lui_q;
  logic [4:0]  rs_1_q;
  logic [4:0]  rs_2_q;
  logic [4:0]  rd_0_q;
  alu_op_t     alu_control_q;
  logic [31:0] writedata_q;
  logic        write_rb_q;
  logic        done_q;
  logic        illegal_q;
  dec_t        dec;

  instr_decoder u_instr_decoder (
    .instr (instr_q),
    .dec   (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      instr_q       <= '0;
      is_lui_q      <= 1'b0;
      rs_1_q        <= '0;
      rs_2_q        <= '0;
      rd_0_q        <= '0;
      alu_control_q <= AluAdd;
      writedata_q   <= '0;
      write_rb_q    <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      write_rb_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          rs_1_q        <= dec.rs1;
          rs_2_q        <= dec.rs2;
          rd_0_q        <= dec.rd;
          alu_control_q <= dec.alu_op;
          is_lui_q      <= dec.is_lui;
          if (dec.illegal) begin
            illegal_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          writedata_q <= is_lui_q ? {instr_q[31:12], 12'b0} : bus.alu_result;
          // Write strobe lands in WB so the register file commits on the edge ending WB.
          write_rb_q  <= (rd_0_q != 5'd0);
          done_q      <= 1'b1;
          state_q     <= StWb;
        end
        StWb: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.busy        = (state_q != StIdle);
  assign bus.rs_1        = rs_1_q;
  assign bus.rs_2        = rs_2_q;
  assign bus.rd_0        = rd_0_q;
  assign bus.alu_control = alu_control_q;
  assign bus.writedata   = writedata_q;
  assign bus.write_rb    = write_rb_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Randomized bench for datapath_controller against a per-instruction behavioural model.
module tb_datapath_controller;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  logic [31:0] last_wd;

  datapath_controller_if bus();

  datapath_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         legal;
    bit         lui;
    logic [2:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } exp_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  // Legal R-type ops indexed by ALU code: funct3 and funct7 per entry.
  function automatic exp_t model(input logic [31:0] w);
    int unsigned f3_tab[8] = '{0, 0, 7, 6, 4, 1, 5, 2};
    int unsigned f7_tab[8] = '{0, 32, 0, 0, 0, 0, 0, 0};
    exp_t e;
    e = '{default: 0};
    if (w[6:0] == 7'h37) begin
      e.legal = 1;
      e.lui   = 1;
      e.rd    = w[11:7];
    end else if (w[6:0] == 7'h33) begin
      for (int k = 0; k < 8; k++) begin
        if (int'(w[14:12]) == f3_tab[k] && int'(w[31:25]) == f7_tab[k]) begin
          e.legal = 1;
          e.op    = 3'(k);
          e.rs1   = w[19:15];
          e.rs2   = w[24:20];
          e.rd    = w[11:7];
        end
      end
    end
    return e;
  endfunction

  // Entered and left at a negedge of an IDLE cycle.
  task automatic run_instr(input logic [31:0] w, input logic [31:0] aluv, input bit hold,
                           input logic [31:0] nxt);
    exp_t        e;
    logic [31:0] wd;
    e  = model(w);
    wd = e.lui ? {w[31:12], 12'b0} : aluv;
    check_eq("ready_idle", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    bus.alu_result  = aluv;
    @(negedge clk);  // T+1
    check_eq("busy_dec", bus.busy, 1);
    check_eq("ready_dec", bus.instr_ready, 0);
    check_eq("wrb_dec", bus.write_rb, 0);
    check_eq("done_dec", bus.done, 0);
    if (hold) begin
      bus.instr = nxt;
    end else begin
      bus.instr_valid = 1'b0;
      bus.instr       = $urandom;
    end
    @(negedge clk);  // T+2
    check_eq("illegal_t2", bus.illegal, e.legal ? 0 : 1);
    check_eq("wrb_t2", bus.write_rb, 0);
    if (!e.legal) begin
      check_eq("ready_ill", bus.instr_ready, 1);
      check_eq("wd_hold_ill", bus.writedata, last_wd);
      return;
    end
    check_eq("rs1", bus.rs_1, e.rs1);
    check_eq("rs2", bus.rs_2, e.rs2);
    check_eq("aluc", bus.alu_control, e.op);
    check_eq("busy_exec", bus.busy, 1);
    @(negedge clk);  // T+3
    check_eq("done_wb", bus.done, 1);
    check_eq("wrb_wb", bus.write_rb, (e.rd != 0) ? 1 : 0);
    check_eq("rd0", bus.rd_0, e.rd);
    check_eq("wdata", bus.writedata, wd);
    last_wd = wd;
    @(negedge clk);  // T+4
    check_eq("ready_t4", bus.instr_ready, 1);
    check_eq("done_t4", bus.done, 0);
    check_eq("wrb_t4", bus.write_rb, 0);
    check_eq("wd_hold", bus.writedata, wd);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 6) w[6:0] = 7'h33;
    else if (sel < 8) w[6:0] = 7'h37;
    sel = $urandom_range(0, 9);
    if (sel < 6) w[31:25] = 7'h00;
    else if (sel < 8) w[31:25] = 7'h20;
    if ($urandom_range(0, 5) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  logic [31:0] prog[40];

  initial begin
    n_pass          = 0;
    n_total         = 0;
    last_wd         = '0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.alu_result  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", bus.instr_ready, 1);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_illegal", bus.illegal, 0);
    check_eq("rst_wrb", bus.write_rb, 0);
    check_eq("rst_wdata", bus.writedata, 0);
    check_eq("rst_rs1", bus.rs_1, 0);
    rst_n = 1'b1;

    run_instr(32'h002081B3, 32'h0000_0007, 0, 0);             // ADD x3,x1,x2
    run_instr(32'h407302B3, 32'h1111_2222, 1, 32'h12345537);  // SUB, hold valid
    run_instr(32'h12345537, 32'hDEAD_BEEF, 0, 0);             // LUI x10
    run_instr(32'h00208033, 32'h0000_0055, 0, 0);             // ADD x0
    run_instr(32'h4020D1B3, 32'h0000_0001, 0, 0);             // SRA
    run_instr(32'h00000013, 32'h0000_0002, 0, 0);             // ADDI opcode

    // Reset asserted during EXEC drops the pending write-back.
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h002081B3;
    bus.alu_result  = 32'hCAFE_0001;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n           = 1'b0;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    check_eq("rstx_busy", bus.busy, 0);
    check_eq("rstx_done", bus.done, 0);
    check_eq("rstx_wrb", bus.write_rb, 0);
    check_eq("rstx_wdata", bus.writedata, 0);
    check_eq("rstx_ready", bus.instr_ready, 1);
    rst_n           = 1'b1;
    bus.instr_valid = 1'b0;
    last_wd         = '0;
    @(negedge clk);
    check_eq("rstx_ready2", bus.instr_ready, 1);
    check_eq("rstx_wrb2", bus.write_rb, 0);

    foreach (prog[i]) prog[i] = rand_instr();
    for (int i = 0; i < 40; i++) begin
      bit hold;
      hold = (i < 39) && ($urandom_range(0, 1) == 1);
      run_instr(prog[i], $urandom, hold, (i < 39) ? prog[i + 1] : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
